// File: rtl/unpack_arbiter.sv
// unpack_arbiter: round-robin arbiter that shares one byte-to-2-bit unpacker
// between num_req_p packed-byte sources. A grant is held for a burst of up to
// burst_len_p bytes (or until last_i). The grant moves only after the unpacker
// reports idle_i, so owner_o always tags the pixels leaving the unpacker.
// Optional feature (macro UNPACK_ARB_TIMEOUT_EN): a burst whose owner has
// dropped valid for timeout_p cycles is abandoned.
module unpack_arbiter #(
  parameter int unsigned num_req_p   = 2,
  parameter int unsigned burst_len_p = 16,
  parameter int unsigned timeout_p   = 64
) (
  input  logic                                          clk_i,
  input  logic                                          reset_ni,
  input  logic [num_req_p-1:0]                          valid_i,
  input  logic [8*num_req_p-1:0]                        data_i,
  input  logic [num_req_p-1:0]                          last_i,
  output logic [num_req_p-1:0]                          ready_o,
  output logic                                          valid_o,
  output logic [7:0]                                    data_o,
  input  logic                                          ready_i,
  input  logic                                          idle_i,
  output logic [num_req_p-1:0]                          grant_o,
  output logic [((num_req_p > 1) ? $clog2(num_req_p) : 1)-1:0] owner_o
);

  localparam int unsigned owner_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned cnt_w_lp   = $clog2(burst_len_p) + 1;

  typedef enum logic [1:0] {
    state_idle  = 2'd0,
    state_burst = 2'd1,
    state_drain = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [owner_w_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [owner_w_lp-1:0]   owner_q, owner_d;
  logic [num_req_p-1:0]    grant_q, grant_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [7:0]              data_q, data_d;

  logic                    pick_found_c;
  logic [owner_w_lp-1:0]   pick_idx_c;
  logic [num_req_p-1:0]    pick_onehot_c;
  logic                    own_valid_c;
  logic                    own_last_c;
  logic [7:0]              own_data_c;
  logic [owner_w_lp-1:0]   rr_next_c;
  logic                    valid_c;
  logic [num_req_p-1:0]    ready_c;

`ifdef UNPACK_ARB_TIMEOUT_EN
  localparam int unsigned to_w_lp = $clog2(timeout_p) + 1;
  logic [to_w_lp-1:0]      to_q, to_d;
`else
  // timeout_p has no effect without the timeout feature
  logic unused_timeout;
  assign unused_timeout = (timeout_p != 0);
`endif

  // First valid requester at or after rr_ptr, wrapping modulo num_req_p
  always_comb begin
    pick_found_c  = 1'b0;
    pick_idx_c    = '0;
    pick_onehot_c = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      int unsigned cand;
      cand = (32'(rr_ptr_q) + i) % num_req_p;
      if (!pick_found_c && valid_i[cand]) begin
        pick_found_c  = 1'b1;
        pick_idx_c    = owner_w_lp'(cand);
        pick_onehot_c = num_req_p'(1) << cand;
      end
    end
  end

  // Select the current owner's byte, valid and last
  always_comb begin
    own_valid_c = 1'b0;
    own_last_c  = 1'b0;
    own_data_c  = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      if (owner_q == owner_w_lp'(k)) begin
        own_valid_c = valid_i[k];
        own_last_c  = last_i[k];
        own_data_c  = data_i[8*k +: 8];
      end
    end
  end

  assign rr_next_c = (owner_q == owner_w_lp'(num_req_p - 1)) ? '0
                                                              : owner_q + owner_w_lp'(1);

  // Next-state and pass-through logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_c  = 1'b0;
    ready_c  = '0;
`ifdef UNPACK_ARB_TIMEOUT_EN
    to_d     = to_q;
`endif
    unique case (state_q)
      state_idle: begin
        if (pick_found_c) begin
          owner_d = pick_idx_c;
          grant_d = pick_onehot_c;
          cnt_d   = '0;
`ifdef UNPACK_ARB_TIMEOUT_EN
          to_d    = '0;
`endif
          state_d = state_burst;
        end
      end
      state_burst: begin
        valid_c = own_valid_c;
        ready_c = grant_q & {num_req_p{ready_i}};
        if (own_valid_c) begin
          data_d = own_data_c;
        end
        if (own_valid_c && ready_i) begin
          cnt_d = cnt_q + cnt_w_lp'(1);
          if (own_last_c || (cnt_q == cnt_w_lp'(burst_len_p - 1))) begin
            state_d = state_drain;
          end
        end
`ifdef UNPACK_ARB_TIMEOUT_EN
        if (own_valid_c) begin
          to_d = '0;
        end else if (to_q == to_w_lp'(timeout_p - 1)) begin
          state_d = state_drain;
        end else begin
          to_d = to_q + to_w_lp'(1);
        end
`endif
      end
      state_drain: begin
        if (idle_i) begin
          rr_ptr_d = rr_next_c;
          grant_d  = '0;
          state_d  = state_idle;
        end
      end
      default: begin
        state_d = state_idle;
        grant_d = '0;
      end
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= state_idle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
`ifdef UNPACK_ARB_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
`ifdef UNPACK_ARB_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign valid_o = valid_c;
  assign ready_o = ready_c;
  assign data_o  = valid_c ? own_data_c : data_q;
  assign grant_o = grant_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_unpack_arbiter.sv
// Self-checking bench for unpack_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_unpack_arbiter;

  localparam int NR = 3;
  localparam int BL = 4;
  localparam int TO = 8;
  localparam int OW = 2;

  logic            clk;
  logic            reset_ni;
  logic [NR-1:0]   valid_i;
  logic [8*NR-1:0] data_i;
  logic [NR-1:0]   last_i;
  logic [NR-1:0]   ready_o;
  logic            valid_o;
  logic [7:0]      data_o;
  logic            ready_i;
  logic            idle_i;
  logic [NR-1:0]   grant_o;
  logic [OW-1:0]   owner_o;

  int errors = 0;
  int checks = 0;

  // model: phase 0 = waiting for requests, 1 = owner streaming, 2 = waiting for drain
  int         m_phase;
  int         m_owner;
  int         m_rr;
  int         m_bytes;
  int         m_idle;
  logic [7:0] m_data;

  logic [7:0] src [3];
  logic [7:0] got [3];

  unpack_arbiter #(
    .num_req_p  (NR),
    .burst_len_p(BL),
    .timeout_p  (TO)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_ni),
    .valid_i (valid_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .idle_i  (idle_i),
    .grant_o (grant_o),
    .owner_o (owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_ni = 1'b0;
    valid_i  = '0;
    last_i   = '0;
    data_i   = '0;
    ready_i  = 1'b1;
    idle_i   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
  endtask

  // Per-cycle compare against the behavioural model, then advance the model
  task automatic monitor();
    logic [NR-1:0] eg;
    logic [NR-1:0] er;
    logic          ev;
    logic [7:0]    ed;
    forever begin
      @(negedge clk);
      if (!reset_ni) begin
        m_phase = 0; m_owner = 0; m_rr = 0; m_bytes = 0; m_idle = 0; m_data = '0;
        eg = '0; er = '0; ev = 1'b0; ed = '0;
      end else begin
        eg = (m_phase == 0) ? '0 : (NR'(1) << m_owner);
        ev = (m_phase == 1) && valid_i[m_owner];
        er = ((m_phase == 1) && ready_i) ? (NR'(1) << m_owner) : '0;
        ed = ev ? data_i[8*m_owner +: 8] : m_data;
      end
      chk("mon_grant", 32'(grant_o), 32'(eg));
      chk("mon_owner", 32'(owner_o), 32'(m_owner));
      chk("mon_valid", 32'(valid_o), 32'(ev));
      chk("mon_ready", 32'(ready_o), 32'(er));
      chk("mon_data",  32'(data_o),  32'(ed));
      if (reset_ni) begin
        case (m_phase)
          0: begin
            if (valid_i != '0) begin
              for (int i = NR - 1; i >= 0; i--) begin
                if (valid_i[(m_rr + i) % NR]) m_owner = (m_rr + i) % NR;
              end
              m_bytes = 0;
              m_idle  = 0;
              m_phase = 1;
            end
          end
          1: begin
            if (ev) begin
              m_data = ed;
              m_idle = 0;
              if (ready_i) begin
                m_bytes++;
                if (last_i[m_owner] || m_bytes == BL) m_phase = 2;
              end
            end else begin
`ifdef UNPACK_ARB_TIMEOUT_EN
              m_idle++;
              if (m_idle == TO) m_phase = 2;
`endif
            end
          end
          default: begin
            if (idle_i) begin
              m_rr    = (m_owner + 1) % NR;
              m_phase = 0;
            end
          end
        endcase
      end
    end
  endtask

  initial begin
    int sent;
    reset_ni = 1'b0;
    valid_i  = '0;
    last_i   = '0;
    data_i   = '0;
    ready_i  = 1'b1;
    idle_i   = 1'b1;
    fork
      monitor();
    join_none

    // reset state
    #2;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_owner", 32'(owner_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_data",  32'(data_o),  32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;

    // single requester, two bytes, then rr_ptr moves to req1
    valid_i = 3'b001; data_i[7:0] = 8'h1B; last_i = '0;
    #1;
    chk("t1_idle_grant", 32'(grant_o), 32'h0);
    chk("t1_idle_valid", 32'(valid_o), 32'h0);
    step();
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_data0", 32'(data_o),  32'h1B);
    chk("t1_ready", 32'(ready_o), 32'h1);
    data_i[7:0] = 8'hE4; last_i = 3'b001;
    #1;
    chk("t1_data1", 32'(data_o), 32'hE4);
    chk("t1_valid1", 32'(valid_o), 32'h1);
    step();
    valid_i = '0; last_i = '0;
    #1;
    chk("t1_drain_valid", 32'(valid_o), 32'h0);
    chk("t1_drain_grant", 32'(grant_o), 32'h1);
    step();
    chk("t1_idle_after_drain", 32'(grant_o), 32'h0);
    valid_i = 3'b011; data_i[15:8] = 8'h55; last_i = 3'b010;
    step();
    chk("t1_rr_grant", 32'(grant_o), 32'h2);
    chk("t1_rr_owner", 32'(owner_o), 32'h1);
    chk("t1_rr_data",  32'(data_o),  32'h55);
    step();
    valid_i = '0; last_i = '0;
    step();

    // contention: req0 and req1 continuously valid, bursts of BL bytes
    apply_reset();
    valid_i = 3'b011; last_i = '0;
    for (int c = 1; c <= 13; c++) begin
      data_i[7:0]  = 8'(8'hA0 + c);
      data_i[15:8] = 8'(8'hB0 + c);
      step();
      if (c == 1)  begin chk("t2_owner_a", 32'(owner_o), 32'h0); chk("t2_grant_a", 32'(grant_o), 32'h1); end
      if (c == 5)  begin chk("t2_drain_valid", 32'(valid_o), 32'h0); chk("t2_drain_grant", 32'(grant_o), 32'h1); end
      if (c == 6)  chk("t2_idle_grant", 32'(grant_o), 32'h0);
      if (c == 7)  begin chk("t2_owner_b", 32'(owner_o), 32'h1); chk("t2_ready_b", 32'(ready_o), 32'h2); end
      if (c == 13) begin chk("t2_owner_c", 32'(owner_o), 32'h0); chk("t2_grant_c", 32'(grant_o), 32'h1); end
    end

    // drain hold while the unpacker is busy
    apply_reset();
    idle_i = 1'b0;
    valid_i = 3'b001; data_i[7:0] = 8'hA5; last_i = 3'b001;
    step();
    chk("t3_data", 32'(data_o), 32'hA5);
    step();
    valid_i = '0; last_i = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_hold_valid", 32'(valid_o), 32'h0);
      chk("t3_hold_owner", 32'(owner_o), 32'h0);
      chk("t3_hold_grant", 32'(grant_o), 32'h1);
      if (i == 9) idle_i = 1'b1;
      step();
    end
    chk("t3_released", 32'(grant_o), 32'h0);

    // backpressure during a 3-byte burst
    apply_reset();
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
    got[0] = '0; got[1] = '0; got[2] = '0;
    sent = 0;
    valid_i = 3'b001; data_i[7:0] = src[0];
    step();
    for (int j = 0; j < 5; j++) begin
      ready_i = ((j % 2) == 0);
      data_i[7:0] = src[sent];
      last_i = (sent == 2) ? 3'b001 : 3'b000;
      #1;
      if (valid_o && ready_i) begin
        got[sent] = data_o;
        sent++;
      end else begin
        chk("t4_stall_data", 32'(data_o), 32'(src[sent]));
      end
      step();
    end
    ready_i = 1'b1;
    #1;
    chk("t4_fires", 32'(sent), 32'd3);
    chk("t4_byte0", 32'(got[0]), 32'h11);
    chk("t4_byte1", 32'(got[1]), 32'h22);
    chk("t4_byte2", 32'(got[2]), 32'h33);
    chk("t4_drain_valid", 32'(valid_o), 32'h0);
    valid_i = '0; last_i = '0;

    // asynchronous reset in the middle of a burst
    apply_reset();
    valid_i = 3'b011; data_i[7:0] = 8'h3C; data_i[15:8] = 8'hC3;
    step();
    step();
    #2;
    reset_ni = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant_o), 32'h0);
    chk("t5_async_valid", 32'(valid_o), 32'h0);
    chk("t5_async_ready", 32'(ready_o), 32'h0);
    @(posedge clk);
    #3;
    reset_ni = 1'b1;
    step();
    chk("t5_regrant", 32'(grant_o), 32'h1);

    // stalled owner: abandoned after TO idle cycles, or held forever
    apply_reset();
    valid_i = 3'b001; data_i[7:0] = 8'h77; last_i = '0;
    step();
    step();
    valid_i = 3'b010;
`ifdef UNPACK_ARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("t6_stall_grant", 32'(grant_o), 32'h1);
      step();
    end
    chk("t6_drain_grant", 32'(grant_o), 32'h1);
    chk("t6_drain_valid", 32'(valid_o), 32'h0);
    step();
    chk("t6_idle_grant", 32'(grant_o), 32'h0);
    step();
    chk("t6_next_owner", 32'(grant_o), 32'h2);
`else
    for (int i = 0; i < 120; i++) begin
      #1;
      chk("t6_hold_grant", 32'(grant_o), 32'h1);
      chk("t6_hold_valid", 32'(valid_o), 32'h0);
      step();
    end
`endif

    // randomized traffic checked by the model
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) apply_reset();
      for (int k = 0; k < NR; k++) begin
        valid_i[k] = ($urandom_range(0, 3) != 0);
        last_i[k]  = ($urandom_range(0, 5) == 0);
        data_i[8*k +: 8] = 8'($urandom);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      idle_i  = ($urandom_range(0, 2) != 0);
      step();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
